// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package wb_pkg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic          live;
        logic [AW-1:0] wr;
        logic [DW-1:0] d;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order circular buffer of pending multi-cycle results with per-entry live
// bits, kill-by-address and address-match outputs for hazard detection.
module wb_queue #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Clrn,
    input  logic                     push,
    input  logic [AW-1:0]            push_wr,
    input  logic [DW-1:0]            push_d,
    input  logic                     pop,
    input  logic                     kill,
    input  logic [AW-1:0]            kill_wr,
    output logic                     head_live,
    output logic [AW-1:0]            head_wr,
    output logic [DW-1:0]            head_d,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [AW-1:0]            chk_a,
    input  logic [AW-1:0]            chk_b,
    output logic                     match_a,
    output logic                     match_b
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          live_q [DEPTH];
    logic [AW-1:0] wr_q   [DEPTH];
    logic [DW-1:0] d_q    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count_q < CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Later assignments override the kill: a popped slot is freed and
            // a freshly pushed entry is always live.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill && live_q[i] && (wr_q[i] == kill_wr)) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (do_pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            if (do_push) begin
                live_q[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset; only live bits decide whether a slot matters.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            wr_q[wr_ptr] <= push_wr;
            d_q[wr_ptr]  <= push_d;
        end
    end

    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (wr_q[i] == chk_a)) match_a = 1'b1;
            if (live_q[i] && (wr_q[i] == chk_b)) match_b = 1'b1;
        end
    end

    assign head_live = live_q[rd_ptr];
    assign head_wr   = wr_q[rd_ptr];
    assign head_d    = d_q[rd_ptr];
    assign count     = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, multi-cycle
// results drain from an in-order queue, hazard flags guard issue-stage reads.
module wb_arbiter #(
    parameter int DW    = wb_pkg::DW,
    parameter int AW    = wb_pkg::AW,
    parameter int DEPTH = wb_pkg::DEPTH
) (
    input  logic                    Clk,
    input  logic                    Clrn,
    input  logic                    AluValid,
    input  logic [AW-1:0]           AluWr,
    input  logic [DW-1:0]           AluD,
    input  logic                    LongValid,
    output logic                    LongReady,
    input  logic [AW-1:0]           LongWr,
    input  logic [DW-1:0]           LongD,
    input  logic [AW-1:0]           ChkRa,
    input  logic [AW-1:0]           ChkRb,
    output logic                    HazA,
    output logic                    HazB,
    output logic                    We,
    output logic [AW-1:0]           Wr,
    output logic [DW-1:0]           D,
    output logic [$clog2(DEPTH):0]  Count
);

    import wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic          alu_wr_en;
    logic          push;
    logic          pop;
    logic          head_live;
    logic [AW-1:0] head_wr;
    logic [DW-1:0] head_d;
    logic          match_a;
    logic          match_b;

    assign alu_wr_en = AluValid && (AluWr != ZERO);
    assign LongReady = Clrn && (Count < CW'(DEPTH));
    // Accepted writes to r0 complete the handshake but are never queued.
    assign push      = LongValid && LongReady && (LongWr != ZERO);
    assign pop       = !alu_wr_en && (Count != '0);

    wb_queue #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_queue (
        .Clk       (Clk),
        .Clrn      (Clrn),
        .push      (push),
        .push_wr   (LongWr),
        .push_d    (LongD),
        .pop       (pop),
        .kill      (alu_wr_en),
        .kill_wr   (AluWr),
        .head_live (head_live),
        .head_wr   (head_wr),
        .head_d    (head_d),
        .count     (Count),
        .chk_a     (ChkRa),
        .chk_b     (ChkRb),
        .match_a   (match_a),
        .match_b   (match_b)
    );

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            We <= 1'b0;
            Wr <= '0;
            D  <= '0;
        end else if (alu_wr_en) begin
            We <= 1'b1;
            Wr <= AluWr;
            D  <= AluD;
        end else if (pop) begin
            We <= head_live;
            if (head_live) begin
                Wr <= head_wr;
                D  <= head_d;
            end
        end else begin
            We <= 1'b0;
        end
    end

    assign HazA = (ChkRa != ZERO) && (match_a || (We && (Wr == ChkRa)));
    assign HazB = (ChkRb != ZERO) && (match_b || (We && (Wr == ChkRb)));

endmodule
